// File: rtl/switch_arbiter_n.sv
// switch_arbiter_n: N-port output arbiter with per-output round-robin
// pointers, all-or-nothing multicast grants and optional watchdog.
module switch_arbiter_n #(
    parameter  int NUM_PORTS = 4,
    parameter  int TIMEOUT   = 0,
    localparam int SEL_W     = $clog2(NUM_PORTS),
    localparam int TO_W      = $clog2(TIMEOUT + 2)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0]           done_i,
    output logic [NUM_PORTS-1:0]           grant_o,
    output logic [NUM_PORTS-1:0]           out_active_o,
    output logic [NUM_PORTS*SEL_W-1:0]     out_sel_o,
    output logic [NUM_PORTS-1:0]           timeout_o
);
    localparam int N = NUM_PORTS;

    logic [N-1:0]       active_q, active_d;
    logic [N-1:0]       to_q, to_d;
    logic [SEL_W-1:0]   sel_q [N];
    logic [SEL_W-1:0]   sel_d [N];
    logic [SEL_W-1:0]   ptr_q [N];
    logic [SEL_W-1:0]   ptr_d [N];
    logic [TO_W-1:0]    cnt_q [N];
    logic [TO_W-1:0]    cnt_d [N];

    logic [N-1:0]       busy;
    logic [N-1:0]       cand_v;
    logic [SEL_W-1:0]   cand [N];
    logic [N-1:0]       grant;
    logic [N-1:0]       g_out;

    // A port owning any active output is busy and masked from candidacy
    always_comb begin
        busy = '0;
        for (int p = 0; p < N; p++) begin
            for (int o = 0; o < N; o++) begin
                if (active_q[o] && sel_q[o] == SEL_W'(p)) busy[p] = 1'b1;
            end
        end
    end

    // Round-robin candidate search per free output starting at its pointer
    always_comb begin
        int idx;
        idx = 0;
        cand_v = '0;
        for (int o = 0; o < N; o++) begin
            cand[o] = '0;
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr_q[o]) + k) % N;
                if (!cand_v[o] && !active_q[o] &&
                    req_i[o*N+idx] && !busy[idx]) begin
                    cand_v[o] = 1'b1;
                    cand[o]   = SEL_W'(idx);
                end
            end
        end
    end

    // A port wins only if it is the candidate of every output it requests
    always_comb begin
        logic any;
        logic ok;
        any   = 1'b0;
        ok    = 1'b1;
        grant = '0;
        for (int p = 0; p < N; p++) begin
            any = 1'b0;
            ok  = 1'b1;
            for (int o = 0; o < N; o++) begin
                if (req_i[o*N+p]) begin
                    any = 1'b1;
                    if (active_q[o] || !cand_v[o] || cand[o] != SEL_W'(p))
                        ok = 1'b0;
                end
            end
            grant[p] = rst_n & any & ok;
        end
    end

    // Outputs taken over by a granted port this cycle
    always_comb begin
        g_out = '0;
        for (int o = 0; o < N; o++) begin
            for (int p = 0; p < N; p++) begin
                if (grant[p] && req_i[o*N+p]) g_out[o] = 1'b1;
            end
        end
    end

    // Ownership, release and watchdog next-state per output
    always_comb begin
        active_d = active_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        to_d     = '0;
        for (int o = 0; o < N; o++) begin
            if (active_q[o]) begin
                if (done_i[o]) begin
                    active_d[o] = 1'b0;
                end else if (TIMEOUT > 0) begin
                    if (cnt_q[o] == TO_W'(TIMEOUT - 1)) begin
                        active_d[o] = 1'b0;
                        to_d[o]     = 1'b1;
                    end else begin
                        cnt_d[o] = cnt_q[o] + 1'b1;
                    end
                end
            end else if (g_out[o]) begin
                active_d[o] = 1'b1;
                sel_d[o]    = cand[o];
                ptr_d[o]    = SEL_W'((int'(cand[o]) + 1) % N);
                cnt_d[o]    = '0;
            end
        end
    end

    // State registers; reset releases every output without a timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            to_q     <= '0;
            for (int o = 0; o < N; o++) begin
                sel_q[o] <= '0;
                ptr_q[o] <= '0;
                cnt_q[o] <= '0;
            end
        end else begin
            active_q <= active_d;
            to_q     <= to_d;
            for (int o = 0; o < N; o++) begin
                sel_q[o] <= sel_d[o];
                ptr_q[o] <= ptr_d[o];
                cnt_q[o] <= cnt_d[o];
            end
        end
    end

    // Flatten per-output selects onto the crossbar bus
    always_comb begin
        out_sel_o = '0;
        for (int o = 0; o < N; o++) begin
            out_sel_o[o*SEL_W +: SEL_W] = sel_q[o];
        end
    end

    assign grant_o      = grant;
    assign out_active_o = active_q;
    assign timeout_o    = to_q;

endmodule

// File: tb/tb_switch_arbiter_n.sv
// tb_switch_arbiter_n: directed plan scenarios plus random traffic
// checked against an array-based arbitration model.
module tb_switch_arbiter_n;
    localparam int N = 4;
    localparam int T = 5;

    logic          clk;
    logic          rst_n;
    logic [15:0]   req;
    logic [3:0]    done;
    logic [3:0]    grant_o;
    logic [3:0]    out_active_o;
    logic [7:0]    out_sel_o;
    logic [3:0]    timeout_o;

    int errors = 0;
    int checks = 0;

    bit m_act [N];
    int m_sel [N];
    int m_ptr [N];
    int m_cnt [N];
    bit m_to  [N];

    switch_arbiter_n #(.NUM_PORTS(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
        .grant_o(grant_o), .out_active_o(out_active_o),
        .out_sel_o(out_sel_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rq(input int o, input int p);
        return 1 << (o * N + p);
    endfunction

    function automatic logic [3:0] mgrant(input logic [15:0] r);
        int  cand [N];
        bit  busy [N];
        bit  any, ok;
        int  idx;
        logic [3:0] g;
        g = '0;
        for (int p = 0; p < N; p++) busy[p] = 0;
        for (int o = 0; o < N; o++) if (m_act[o]) busy[m_sel[o]] = 1;
        for (int o = 0; o < N; o++) begin
            cand[o] = -1;
            if (!m_act[o]) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr[o] + k) % N;
                    if (cand[o] < 0 && r[o*N+idx] && !busy[idx]) cand[o] = idx;
                end
            end
        end
        for (int p = 0; p < N; p++) begin
            any = 0;
            ok  = 1;
            for (int o = 0; o < N; o++) begin
                if (r[o*N+p]) begin
                    any = 1;
                    if (m_act[o] || cand[o] != p) ok = 0;
                end
            end
            g[p] = any && ok;
        end
        return g;
    endfunction

    function automatic logic [3:0] e_act();
        logic [3:0] v;
        for (int o = 0; o < N; o++) v[o] = m_act[o];
        return v;
    endfunction

    function automatic logic [3:0] e_to();
        logic [3:0] v;
        for (int o = 0; o < N; o++) v[o] = m_to[o];
        return v;
    endfunction

    function automatic logic [7:0] e_sel();
        logic [7:0] v;
        for (int o = 0; o < N; o++) v[o*2 +: 2] = 2'(m_sel[o]);
        return v;
    endfunction

    task automatic mreset();
        for (int o = 0; o < N; o++) begin
            m_act[o] = 0; m_sel[o] = 0; m_ptr[o] = 0;
            m_cnt[o] = 0; m_to[o]  = 0;
        end
    endtask

    task automatic mstep(input logic [15:0] r, input logic [3:0] d);
        logic [3:0] g;
        g = mgrant(r);
        for (int o = 0; o < N; o++) begin
            m_to[o] = 0;
            if (m_act[o]) begin
                if (d[o]) m_act[o] = 0;
                else if (m_cnt[o] == T - 1) begin
                    m_act[o] = 0;
                    m_to[o]  = 1;
                end else m_cnt[o]++;
            end
        end
        for (int p = 0; p < N; p++) begin
            if (g[p]) begin
                for (int o = 0; o < N; o++) begin
                    if (r[o*N+p]) begin
                        m_act[o] = 1;
                        m_sel[o] = p;
                        m_ptr[o] = (p + 1) % N;
                        m_cnt[o] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [15:0] r, input logic [3:0] d);
        req  = r;
        done = d;
        #2;
        chk("grant", 16'(grant_o), 16'(mgrant(r)));
        chk("active", 16'(out_active_o), 16'(e_act()));
        chk("sel", 16'(out_sel_o), 16'(e_sel()));
        chk("timeout", 16'(timeout_o), 16'(e_to()));
        @(posedge clk);
        mstep(r, d);
        #1;
    endtask

    task automatic gchk(input string tag, input logic [15:0] r,
                        input logic [3:0] exp);
        req = r;
        #1;
        chk(tag, 16'(grant_o), 16'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_active", 16'(out_active_o), 16'h0);
        chk("rst_grant", 16'(grant_o), 16'h0);
        chk("rst_timeout", 16'(timeout_o), 16'h0);
        mreset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r;
        logic [3:0]  d;
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        #3;
        do_reset();
        chk("rst_sel", 16'(out_sel_o), 16'h0);

        // Unicast grant, then release
        gchk("s1_grant", 16'(rq(2, 0)), 4'b0001);
        step(16'(rq(2, 0)), 4'b0000);
        chk("s1_act", 16'(out_active_o), 16'h4);
        chk("s1_sel", 16'(out_sel_o), 16'h00);
        step(16'h0, 4'b0100);
        chk("s1_rel", 16'(out_active_o), 16'h0);
        step(16'h0, 4'b0000);

        // Round-robin alternation on out0 between ports 1 and 3
        do_reset();
        r = 16'(rq(0, 1) | rq(0, 3));
        for (int i = 0; i < 4; i++) begin
            gchk("s2_rr", r, (i % 2 == 0) ? 4'b0010 : 4'b1000);
            step(r, 4'b0000);
            step(r, 4'b0000);
            step(r, 4'b0000);
            step(r, 4'b0001);
        end

        // Multicast reservation
        do_reset();
        step(16'(rq(1, 0)), 4'b0000);
        r = 16'(rq(0, 2) | rq(1, 2) | rq(3, 2) | rq(0, 3));
        gchk("s3_block", r, 4'b0000);
        step(r, 4'b0000);
        step(r, 4'b0000);
        chk("s3_free", 16'(out_active_o), 16'h2);
        step(r, 4'b0010);
        gchk("s3_mc", r, 4'b0100);
        step(r, 4'b0000);
        chk("s3_act", 16'(out_active_o), 16'hB);
        chk("s3_sel", 16'(out_sel_o & 8'hCF), 16'h8A);

        // Watchdog force-release
        do_reset();
        step(16'(rq(3, 1)), 4'b0000);
        for (int i = 0; i < T; i++) begin
            chk("s4_hold", 16'(out_active_o), 16'h8);
            step(16'(rq(3, 2)), 4'b0000);
        end
        chk("s4_pulse", 16'(timeout_o), 16'h8);
        gchk("s4_regrant", 16'(rq(3, 2)), 4'b0100);
        step(16'(rq(3, 2)), 4'b0000);
        chk("s4_once", 16'(timeout_o), 16'h0);
        chk("s4_sel", 16'(out_sel_o), 16'h80);

        // Done on the last allowed cycle wins over the watchdog
        do_reset();
        step(16'(rq(3, 1)), 4'b0000);
        for (int i = 0; i < T - 1; i++) step(16'h0, 4'b0000);
        step(16'h0, 4'b1000);
        chk("s5_nopulse", 16'(timeout_o), 16'h0);
        chk("s5_rel", 16'(out_active_o), 16'h0);
        step(16'h0, 4'b0000);

        // Reset mid-ownership and pointer restart
        do_reset();
        step(16'(rq(0, 1) | rq(2, 1)), 4'b0000);
        step(16'(rq(1, 1)), 4'b0000);
        chk("s6_pre", 16'(out_active_o), 16'h5);
        req = 16'(rq(0, 0) | rq(0, 3));
        do_reset();
        gchk("s6_ptr0", 16'(rq(0, 0) | rq(0, 3)), 4'b0001);
        step(16'(rq(0, 0) | rq(0, 3)), 4'b0000);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = 16'($urandom & $urandom);
            d = 4'($urandom & $urandom);
            step(r, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/switch_arbiter_n.md
Name: switch_arbiter_n

Overview:
Parametrised N-port output arbiter for the packet switch. It generalises the fixed 4-port common-pointer arbiter. Each output has its own round-robin pointer. Multicast/broadcast requests get all-or-nothing grants. Granted outputs are held until the transmitting port signals done, with an optional per-output watchdog timeout. It sits between the per-port FSMs (ARB_WAIT/TRANSMIT) and the crossbar muxes.

Parameters:
NUM_PORTS, 4, number of input ports = number of outputs; legal range 2..16.
TIMEOUT, 0, max cycles an output may stay active without done; 0 disables the watchdog.
SEL_W, $clog2(NUM_PORTS), derived localparam: width of one mux select.
TO_W, $clog2(TIMEOUT+2), derived localparam: watchdog counter width.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  reset; asynchronous, active-low.
req_i  input  NUM_PORTS*NUM_PORTS  bit o*NUM_PORTS+p = input port p requests output o. Multiple bits per port = multicast.
done_i  input  NUM_PORTS  bit o = packet on output o finished; releases output o.
grant_o  output  NUM_PORTS  bit p = port p granted all its requested outputs this cycle; combinational.
out_active_o  output  NUM_PORTS  bit o = output o currently owned; registered.
out_sel_o  output  NUM_PORTS*SEL_W  field o = owning input port of output o; registered.
timeout_o  output  NUM_PORTS  bit o = one-cycle pulse when output o is force-released by the watchdog.

Behaviour:
- Reset (rst_n low, async): out_active_o=0, out_sel_o=0, all per-output pointers ptr[o]=0, all watchdog counters=0, timeout_o=0. grant_o is forced 0 while rst_n is low.
- Candidate per output o, combinational: only when out_active_o[o]=0. It is the first p scanning ptr[o], ptr[o]+1, ... mod NUM_PORTS with request bit (o,p) set and port p not busy. If none, there is no candidate.
- Busy port: p owns at least one active output. A busy port is masked from all candidacy.
- Grant rule: grant_o[p]=1 iff port p has at least one request bit set and, for every output o it requests, o is inactive and candidate(o)==p. Partial grants never occur.
- Reservation: a free output whose candidate p is blocked (another requested output is busy or has a different candidate) stays free. Its ptr[o] holds, so no other port can take it. This guarantees multicast progress and prevents livelock.
- On grant of p, at the next edge, for each requested o:
  - out_active_o[o]<=1
  - out_sel_o[o]<=p
  - ptr[o]<=(p+1) mod NUM_PORTS
  - watchdog[o]<=0
- Latency: grant is same-cycle with the request. Mux select and active are valid one cycle after the grant.
- Release: done_i[o]=1 while out_active_o[o]=1 clears active at the next edge. out_sel_o holds its last value. done_i on an inactive output is ignored.
- Re-use: a freed output can be granted no earlier than the cycle after active clears. A grant and a release never occur on the same output in the same cycle.
- ptr[o] does not change on cycles without a grant on o.
- Watchdog (TIMEOUT>0):
  - Counter runs while active and done_i[o]=0.
  - When the counter reaches TIMEOUT-1 with no done, the next edge clears active and pulses timeout_o[o] for exactly one cycle.
  - done_i[o] in the same cycle takes precedence: normal release, no pulse.
- Request withdrawal before grant has no side effects. Request bits held during ownership are ignored (port is busy).
- Reset mid-ownership: all outputs are released immediately and no timeout pulse is generated.

Test Plan:
- N=4. Port0 req out2 only → grant_o=0001 same cycle; next cycle out_active_o[2]=1, sel2=0. done_i[2] → active clears the following cycle.
- Ports 1 and 3 both request out0 continuously, each asserting done after 3 active cycles → grants alternate 1,3,1,3 with ptr[0] advancing to 2 then 0.
- Port2 multicast req outs {0,1,3}, out1 owned by port0 → grant_o[2]=0 and outs 0 and 3 stay free. Port3 also requests out0 → port3 is not granted while port2 is candidate. On out1 done → port2 granted all three simultaneously, sel=2 on outs 0, 1 and 3.
- TIMEOUT=5, port1 owns out3 with no done → active for 5 cycles, timeout_o[3] single-cycle pulse, then port2 waiting on out3 is granted the next cycle.
- TIMEOUT=5, done_i[3] asserted on the 5th active cycle → normal release, timeout_o stays 0.
- rst_n pulled low mid-transfer with outs 0 and 2 active → out_active_o=0000, grant_o=0000 immediately. After release, the first grant uses ptr=0 ordering (port0 wins over port3 for the same output).
